// File: rtl/note_tone_player.sv
// note_tone_player: turns a record/replay note code (or live key code) into a
// square-wave speaker output, with a silent articulation gap between notes.
module note_tone_player #(
    parameter int unsigned GAP_CYCLES = 25000
) (
    input  logic       clk_5MHz,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] note_in,
    output logic       audio_out,
    output logic       playing,
    output logic [7:0] cur_note
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned CODE_W = 8;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_PLAY
    } state_t;

    state_t              r_state;
    logic [CODE_W-1:0]   r_cur_note;
    logic [CNT_W-1:0]    r_gap_cnt;
    logic [CNT_W-1:0]    r_tone_cnt;
    logic                r_audio;
    logic                r_playing;

    state_t              w_state_nxt;
    logic [CODE_W-1:0]   w_cur_nxt;
    logic [CNT_W-1:0]    w_gap_nxt;
    logic [CNT_W-1:0]    w_tone_nxt;
    logic                w_audio_nxt;
    logic                w_playing_nxt;

    logic [3:0]          w_semi;
    logic [CODE_W-1:0]   w_norm;
    logic [CNT_W-1:0]    w_half;
    logic [CNT_W-1:0]    w_half_last;
    logic                w_unused_hi;

    // C4..C5 base half-periods in clock cycles; index 0 is never played
    function automatic logic [CNT_W-1:0] half_base(input logic [3:0] n);
        case (n)
            4'd1:    half_base = 16'd9556;
            4'd2:    half_base = 16'd9019;
            4'd3:    half_base = 16'd8513;
            4'd4:    half_base = 16'd8035;
            4'd5:    half_base = 16'd7584;
            4'd6:    half_base = 16'd7159;
            4'd7:    half_base = 16'd6757;
            4'd8:    half_base = 16'd6378;
            4'd9:    half_base = 16'd6020;
            4'd10:   half_base = 16'd5682;
            4'd11:   half_base = 16'd5363;
            4'd12:   half_base = 16'd5062;
            4'd13:   half_base = 16'd4778;
            default: half_base = 16'd0;
        endcase
    endfunction

    // Bits [7:6] of the note code carry no meaning here
    assign w_unused_hi = ^note_in[7:6];

    // Normalize the incoming code: out-of-range semitones collapse to silence
    assign w_semi      = note_in[3:0];
    assign w_norm      = ((w_semi == 4'd0) || (w_semi > 4'd13)) ? 8'h00
                                                                : {2'b00, note_in[5:4], w_semi};
    assign w_half      = half_base(r_cur_note[3:0]) >> r_cur_note[5:4];
    assign w_half_last = CNT_W'(w_half - 16'd1);

    // State and datapath registers
    always_ff @(posedge clk_5MHz or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cur_note <= '0;
            r_gap_cnt  <= '0;
            r_tone_cnt <= '0;
            r_audio    <= 1'b0;
            r_playing  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_note <= w_cur_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_tone_cnt <= w_tone_nxt;
            r_audio    <= w_audio_nxt;
            r_playing  <= w_playing_nxt;
        end
    end

    // Next-state logic: enable first, then note change (restarts the gap), then per-state work
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur_note;
        w_gap_nxt   = r_gap_cnt;
        w_tone_nxt  = r_tone_cnt;
        w_audio_nxt = r_audio;

        if (!en) begin
            w_state_nxt = S_IDLE;
            w_cur_nxt   = '0;
            w_audio_nxt = 1'b0;
        end else if (w_norm != r_cur_note) begin
            w_cur_nxt   = w_norm;
            w_state_nxt = S_GAP;
            w_gap_nxt   = '0;
            w_audio_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_audio_nxt = 1'b0;
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        if (r_cur_note == 8'h00) begin
                            w_state_nxt = S_IDLE;
                            w_audio_nxt = 1'b0;
                        end else begin
                            w_state_nxt = S_PLAY;
                            w_audio_nxt = 1'b1;
                            w_tone_nxt  = '0;
                        end
                    end else begin
                        w_gap_nxt = CNT_W'(r_gap_cnt + 16'd1);
                    end
                end
                S_PLAY: begin
                    if (r_tone_cnt == w_half_last) begin
                        w_audio_nxt = ~r_audio;
                        w_tone_nxt  = '0;
                    end else begin
                        w_tone_nxt = CNT_W'(r_tone_cnt + 16'd1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_audio_nxt = 1'b0;
                end
            endcase
        end

        w_playing_nxt = (w_state_nxt == S_PLAY);
    end

    assign audio_out = r_audio;
    assign playing   = r_playing;
    assign cur_note  = r_cur_note;

endmodule

// File: tb/tb_note_tone_player.sv
// Bench for note_tone_player: two instances (long and short gap) share stimulus;
// a timeline model predicts every output on every cycle.
module tb_note_tone_player;

    localparam int unsigned GAP_L = 25000;
    localparam int unsigned GAP_S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] note;

    logic       aud_l, ply_l, aud_s, ply_s;
    logic [7:0] cur_l, cur_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] m_cur [2] = '{8'h00, 8'h00};
    int         m_chg [2] = '{0, 0};

    int H0 [13] = '{9556, 9019, 8513, 8035, 7584, 7159, 6757, 6378, 6020, 5682, 5363, 5062, 4778};

    note_tone_player #(.GAP_CYCLES(GAP_L)) u_dut_long (
        .clk_5MHz (clk),
        .reset    (rst),
        .en       (en),
        .note_in  (note),
        .audio_out(aud_l),
        .playing  (ply_l),
        .cur_note (cur_l)
    );

    note_tone_player #(.GAP_CYCLES(GAP_S)) u_dut_short (
        .clk_5MHz (clk),
        .reset    (rst),
        .en       (en),
        .note_in  (note),
        .audio_out(aud_s),
        .playing  (ply_s),
        .cur_note (cur_s)
    );

    always #100 clk = ~clk;

    function automatic logic [7:0] norm_code(input logic [7:0] c);
        int n;
        n = int'(c[3:0]);
        if (n == 0 || n > 13) return 8'h00;
        return {2'b00, c[5:4], c[3:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: remember the edge at which each instance latched its current note
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst || !en) begin
                m_cur[i] = 8'h00;
            end else if (norm_code(note) != m_cur[i]) begin
                m_cur[i] = norm_code(note);
                m_chg[i] = cyc;
            end
        end
    end

    // Compare: output is silent for the gap, then alternates every H cycles
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic       ea, ep;
            logic [7:0] ec;
            int         g, el, h;
            g  = (i == 0) ? GAP_L : GAP_S;
            el = cyc - m_chg[i];
            ea = 1'b0;
            ep = 1'b0;
            ec = 8'h00;
            if (!rst) begin
                ec = m_cur[i];
                if (ec != 8'h00 && el >= g) begin
                    h  = H0[int'(ec[3:0]) - 1] >> ec[5:4];
                    ea = (((el - g) / h) % 2) == 0;
                    ep = 1'b1;
                end
            end
            if (i == 0) begin
                chk("model_audio_long", aud_l, ea);
                chk("model_playing_long", ply_l, ep);
                chk("model_cur_long", cur_l, ec);
            end else begin
                chk("model_audio_short", aud_s, ea);
                chk("model_playing_short", ply_s, ep);
                chk("model_cur_short", cur_s, ec);
            end
        end
    end

    // Directed sequence with hand-computed expectations
    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        note = 8'h00;
        #250;
        chk("reset_audio", aud_l, 0);
        chk("reset_playing", ply_s, 0);
        chk("reset_cur", cur_s, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);

        // A4 with the long gap
        en   = 1'b1;
        note = 8'h0A;
        tick(25000);
        chk("a4_gap_last", aud_l, 0);
        tick(1);
        chk("a4_rise", aud_l, 1);
        chk("a4_playing", ply_l, 1);
        chk("a4_cur", cur_l, 8'h0A);
        tick(5681);
        chk("a4_high_end", aud_l, 1);
        tick(1);
        chk("a4_fall", aud_l, 0);
        tick(5682);
        chk("a4_rise2", aud_l, 1);

        // A5: new gap then half-period 2841
        note = 8'h1A;
        tick(1);
        chk("a5_silent", aud_l, 0);
        chk("a5_cur", cur_l, 8'h1A);
        tick(24999);
        chk("a5_gap_last", aud_l, 0);
        tick(1);
        chk("a5_rise", aud_l, 1);
        tick(2840);
        chk("a5_high_end", aud_l, 1);
        tick(1);
        chk("a5_fall", aud_l, 0);

        // Upper bits differ only: no change
        note = 8'hDA;
        tick(3000);
        chk("da_cur_same", cur_l, 8'h1A);
        chk("da_still_playing", ply_l, 1);

        // Out-of-range semitone then zero: silence through a gap
        note = 8'h0E;
        tick(1);
        chk("silence_cur", cur_s, 8'h00);
        chk("silence_audio", aud_s, 0);
        note = 8'h00;
        tick(10);
        chk("silence_idle_playing", ply_s, 0);
        chk("silence_idle_audio", aud_s, 0);

        // Gap restart on the short instance
        note = 8'h01;
        tick(2);
        note = 8'h0D;
        tick(4);
        chk("c5_gap_restart", aud_s, 0);
        tick(1);
        chk("c5_rise", aud_s, 1);
        chk("c5_cur", cur_s, 8'h0D);
        tick(4777);
        chk("c5_high_end", aud_s, 1);
        tick(1);
        chk("c5_fall", aud_s, 0);

        // Highest pitch, then enable drop and re-enable
        note = 8'h3D;
        tick(5);
        chk("c8_rise", aud_s, 1);
        tick(100);
        en = 1'b0;
        tick(1);
        chk("en_drop_audio", aud_s, 0);
        chk("en_drop_cur", cur_s, 8'h00);
        chk("en_drop_playing", ply_s, 0);
        tick(3);
        en = 1'b1;
        tick(4);
        chk("reen_gap", aud_s, 0);
        tick(1);
        chk("reen_rise", aud_s, 1);
        tick(596);
        chk("c8_high_end", aud_s, 1);
        tick(1);
        chk("c8_fall", aud_s, 0);

        // Asynchronous reset between edges, then a full gap on release
        tick(200);
        chk("pre_rst_playing", ply_s, 1);
        @(posedge clk);
        #40;
        rst = 1'b1;
        #1;
        chk("async_rst_audio", aud_s, 0);
        chk("async_rst_playing", ply_s, 0);
        chk("async_rst_cur", cur_s, 8'h00);
        note = 8'h05;
        tick(2);
        rst = 1'b0;
        tick(4);
        chk("post_rst_gap", aud_s, 0);
        tick(1);
        chk("post_rst_rise", aud_s, 1);
        chk("post_rst_cur", cur_s, 8'h05);
        tick(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
